// File: rtl/aes_inv_key_schedule_if.sv
// Handshake bundle between the reverse AES-128 key schedule and its consumer.
// The slave modport is the key schedule; the master modport drives start/key and accepts beats.
interface aes_inv_key_schedule_if;
   logic         start;
   logic [127:0] last_key;
   logic         busy;
   logic         rk_valid;
   logic         rk_ready;
   logic [127:0] round_key;
   logic [3:0]   rk_round;
   logic         done;

   modport master (
      output start, last_key, rk_ready,
      input  busy, rk_valid, round_key, rk_round, done
   );

   modport slave (
      input  start, last_key, rk_ready,
      output busy, rk_valid, round_key, rk_round, done
   );
endinterface

// File: rtl/aes_inv_key_schedule.sv
// Reverse AES-128 key schedule: starts from the round-10 key and emits round keys
// 10 down to 0, one inverse step per accepted beat, for the decryption datapath.
module aes_inv_key_schedule #(
   parameter int ROUNDS = 10
) (
   input logic                   clk,
   input logic                   rst,
   aes_inv_key_schedule_if.slave ks
);

   generate
      if (ROUNDS != 10) begin : g_bad_rounds
         $error("aes_inv_key_schedule supports only ROUNDS=10 (AES-128)");
      end
   endgenerate

   localparam logic [3:0] LAST_ROUND = 4'(ROUNDS);

   localparam logic [7:0] SBOX [256] = '{
      8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
      8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
      8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
      8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
      8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
      8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
      8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
      8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
      8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
      8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
      8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
      8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
      8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
      8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
      8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
      8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
   };

   function automatic logic [31:0] sub_word(input logic [31:0] w);
      return {SBOX[w[31:24]], SBOX[w[23:16]], SBOX[w[15:8]], SBOX[w[7:0]]};
   endfunction

   function automatic logic [7:0] rcon(input logic [3:0] r);
      logic [7:0] rc;
      case (r)
         4'd1:    rc = 8'h01;
         4'd2:    rc = 8'h02;
         4'd3:    rc = 8'h04;
         4'd4:    rc = 8'h08;
         4'd5:    rc = 8'h10;
         4'd6:    rc = 8'h20;
         4'd7:    rc = 8'h40;
         4'd8:    rc = 8'h80;
         4'd9:    rc = 8'h1b;
         4'd10:   rc = 8'h36;
         default: rc = 8'h00;
      endcase
      return rc;
   endfunction

   typedef enum logic {IDLE, RUN} state_e;

   state_e       state_q, state_d;
   logic [127:0] key_q, key_d;
   logic [3:0]   round_q, round_d;
   logic         done_q, done_d;

   logic [31:0]  w0, w1, w2, w3;
   logic [31:0]  p0, p1, p2, p3;
   logic [127:0] prev_key;

   // Undo one forward step: the three low words fall out of neighbour XORs,
   // and w0 needs the same RotWord/SubWord/Rcon term the forward schedule added.
   always_comb begin
      {w0, w1, w2, w3} = key_q;
      p3 = w3 ^ w2;
      p2 = w2 ^ w1;
      p1 = w1 ^ w0;
      p0 = w0 ^ sub_word({p3[23:0], p3[31:24]}) ^ {rcon(round_q), 24'h0};
      prev_key = {p0, p1, p2, p3};
   end

   // NOTE: every signal gets its default before the case so no path leaves it unassigned (no latches).
   always_comb begin
      state_d = state_q;
      key_d   = key_q;
      round_d = round_q;
      done_d  = 1'b0;
      case (state_q)
         IDLE: begin
            if (ks.start) begin
               key_d   = ks.last_key;
               round_d = LAST_ROUND;
               state_d = RUN;
            end
         end
         RUN: begin
            if (ks.rk_ready) begin
               if (round_q != 4'd0) begin
                  key_d   = prev_key;
                  round_d = round_q - 4'd1;
               end else begin
                  state_d = IDLE;
                  done_d  = 1'b1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         key_q   <= '0;
         round_q <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         key_q   <= key_d;
         round_q <= round_d;
         done_q  <= done_d;
      end
   end

   assign ks.busy      = (state_q == RUN);
   assign ks.rk_valid  = (state_q == RUN);
   assign ks.round_key = key_q;
   assign ks.rk_round  = round_q;
   assign ks.done      = done_q;

endmodule

// File: tb/tb_aes_inv_key_schedule.sv
// Self-checking bench for aes_inv_key_schedule: expected round keys come from a forward
// KeyExpansion model whose S-box is derived from GF(2^8) inversion plus the affine map.
module tb_aes_inv_key_schedule;

   logic clk = 1'b0;
   logic rst;
   int   tests_run    = 0;
   int   tests_failed = 0;

   logic [7:0]   sbox_ref [256];
   logic [127:0] exp_keys [11];
   logic [127:0] obs_keys [11];

   aes_inv_key_schedule_if bus ();

   aes_inv_key_schedule #(.ROUNDS(10)) dut (
      .clk (clk),
      .rst (rst),
      .ks  (bus)
   );

   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout observed=hang expected=finish");
      $fatal(1, "simulation time limit reached");
   end

   function automatic logic [7:0] gf_mul(input logic [7:0] a_in, input logic [7:0] b_in);
      logic [7:0] a, b, p;
      a = a_in;
      b = b_in;
      p = 8'h00;
      for (int i = 0; i < 8; i++) begin
         if (b[0]) p = p ^ a;
         a = {a[6:0], 1'b0} ^ (a[7] ? 8'h1b : 8'h00);
         b = {1'b0, b[7:1]};
      end
      return p;
   endfunction

   task automatic build_sbox();
      logic [7:0] inv, t, s;
      for (int x = 0; x < 256; x++) begin
         inv = 8'h00;
         for (int y = 1; y < 256; y++)
            if (gf_mul(8'(x), 8'(y)) == 8'h01) inv = 8'(y);
         t = inv;
         s = inv;
         for (int n = 0; n < 4; n++) begin
            t = {t[6:0], t[7]};
            s = s ^ t;
         end
         sbox_ref[x] = s ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] sub_word_ref(input logic [31:0] w);
      return {sbox_ref[w[31:24]], sbox_ref[w[23:16]], sbox_ref[w[15:8]], sbox_ref[w[7:0]]};
   endfunction

   // Forward FIPS-197 KeyExpansion; fills exp_keys[0..10].
   task automatic key_expand(input logic [127:0] k0);
      logic [31:0] w [44];
      logic [31:0] t;
      logic [7:0]  rc;
      rc = 8'h01;
      for (int i = 0; i < 4; i++) w[i] = k0[127 - 32*i -: 32];
      for (int i = 4; i < 44; i++) begin
         t = w[i-1];
         if (i % 4 == 0) begin
            t  = sub_word_ref({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = gf_mul(rc, 8'h02);
         end
         w[i] = w[i-4] ^ t;
      end
      for (int r = 0; r < 11; r++) exp_keys[r] = {w[4*r], w[4*r+1], w[4*r+2], w[4*r+3]};
   endtask

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp_v);
      tests_run++;
      assert (obs === exp_v) else begin
         tests_failed++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp_v);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // stall: 0 = rk_ready held high, 1 = random rk_ready, 2 = rk_ready low 3 cycles at round 5.
   // poke: pulse start with an unrelated key while the walk is busy.
   // Returns at the cycle where done should be visible.
   task automatic do_walk(input logic [127:0] k0, input int stall, input bit poke, input string tag);
      int r, cyc, held;
      bit rdy;
      key_expand(k0);
      bus.start    = 1'b1;
      bus.last_key = exp_keys[10];
      bus.rk_ready = 1'b1;
      step();
      bus.start = 1'b0;
      r    = 10;
      cyc  = 0;
      held = 0;
      while (r >= 0 && cyc < 100) begin
         check({tag, "_valid"}, 128'(bus.rk_valid), 128'd1);
         check({tag, "_busy"}, 128'(bus.busy), 128'd1);
         check({tag, "_done_low"}, 128'(bus.done), 128'd0);
         check($sformatf("%s_round_idx_r%0d", tag, r), 128'(bus.rk_round), 128'(r));
         check($sformatf("%s_round_key_r%0d", tag, r), bus.round_key, exp_keys[r]);
         obs_keys[r] = bus.round_key;
         if (stall == 1)                   rdy = 1'($urandom_range(0, 1));
         else if (stall == 2 && r == 5 && held < 3) begin
            rdy = 1'b0;
            held++;
         end else                          rdy = 1'b1;
         bus.rk_ready = rdy;
         if (poke && r == 7) begin
            bus.start    = 1'b1;
            bus.last_key = {$urandom, $urandom, $urandom, $urandom};
         end else begin
            bus.start = 1'b0;
         end
         step();
         cyc++;
         if (rdy) r--;
      end
      bus.start    = 1'b0;
      bus.rk_ready = 1'b1;
      check({tag, "_walk_completed"}, 128'(r < 0), 128'd1);
      if (stall == 0) check({tag, "_start_to_done_cycles"}, 128'(cyc + 1), 128'd12);
      check({tag, "_done_pulse"}, 128'(bus.done), 128'd1);
      check({tag, "_done_busy"}, 128'(bus.busy), 128'd0);
      check({tag, "_done_valid"}, 128'(bus.rk_valid), 128'd0);
      check({tag, "_hold_round"}, 128'(bus.rk_round), 128'd0);
      check({tag, "_hold_key"}, bus.round_key, exp_keys[0]);
   endtask

   task automatic after_done(input string tag);
      step();
      check({tag, "_done_one_cycle"}, 128'(bus.done), 128'd0);
      check({tag, "_idle_valid"}, 128'(bus.rk_valid), 128'd0);
   endtask

   localparam logic [127:0] KEY_V1 = 128'h000102030405060708090a0b0c0d0e0f;
   localparam logic [127:0] KEY_V2 = 128'h2b7e151628aed2a6abf7158809cf4f3c;

   initial begin
      rst          = 1'b1;
      bus.start    = 1'b0;
      bus.last_key = '0;
      bus.rk_ready = 1'b0;
      build_sbox();
      step();
      step();
      check("rst_busy", 128'(bus.busy), 128'd0);
      check("rst_valid", 128'(bus.rk_valid), 128'd0);
      check("rst_done", 128'(bus.done), 128'd0);
      check("rst_round_key", bus.round_key, 128'd0);
      check("rst_rk_round", 128'(bus.rk_round), 128'd0);
      rst = 1'b0;
      step();
      check("idle_hold_valid", 128'(bus.rk_valid), 128'd0);
      check("idle_hold_busy", 128'(bus.busy), 128'd0);

      do_walk(KEY_V1, 0, 1'b0, "v1");
      check("v1_const_r10", obs_keys[10], 128'h13111d7fe3944a17f307a78b4d2b30c5);
      check("v1_const_r9", obs_keys[9], 128'h549932d1f08557681093ed9cbe2c974e);
      check("v1_const_r0", obs_keys[0], 128'h000102030405060708090a0b0c0d0e0f);
      after_done("v1");

      do_walk(KEY_V2, 0, 1'b0, "v2");
      check("v2_const_r10", obs_keys[10], 128'hd014f9a8c9ee2589e13f0cc8b6630ca6);
      check("v2_const_r9", obs_keys[9], 128'hac7766f319fadc2128d12941575c006e);
      check("v2_const_r1", obs_keys[1], 128'ha0fafe1788542cb123a339392a6c7605);
      check("v2_const_r0", obs_keys[0], 128'h2b7e151628aed2a6abf7158809cf4f3c);
      after_done("v2");

      do_walk(KEY_V1, 2, 1'b0, "bp_fixed");
      after_done("bp_fixed");
      do_walk(KEY_V1, 1, 1'b0, "bp_rand");
      after_done("bp_rand");

      do_walk(KEY_V1, 0, 1'b1, "poke");
      do_walk(KEY_V2, 0, 1'b0, "chain");
      after_done("chain");

      bus.start    = 1'b1;
      bus.last_key = 128'h13111d7fe3944a17f307a78b4d2b30c5;
      bus.rk_ready = 1'b1;
      step();
      bus.start = 1'b0;
      for (int i = 0; i < 20 && bus.rk_round != 4'd6; i++) step();
      check("midrst_reached_r6", 128'(bus.rk_round), 128'd6);
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("midrst_valid", 128'(bus.rk_valid), 128'd0);
      check("midrst_busy", 128'(bus.busy), 128'd0);
      check("midrst_done", 128'(bus.done), 128'd0);
      check("midrst_round_key", bus.round_key, 128'd0);
      check("midrst_rk_round", 128'(bus.rk_round), 128'd0);
      step();
      check("midrst_no_done", 128'(bus.done), 128'd0);
      do_walk(KEY_V1, 0, 1'b0, "post_rst");
      after_done("post_rst");

      for (int k = 0; k < 5; k++) begin
         do_walk({$urandom, $urandom, $urandom, $urandom}, k % 2, 1'b0, $sformatf("rt%0d", k));
         after_done($sformatf("rt%0d", k));
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
